uvmt_axis_st_buf_dut: RTL and testbench
=======================================

UVMT_AXIS_ST_BUF_DUT -- requirements
Module: uvmt_axis_st_buf_dut

Interface
REQ-001 SHALL have parameter TDATA_BYTES, default 4: tdata width in bytes; tstrb/tkeep width equals TDATA_BYTES.
REQ-002 SHALL have parameter TID_WIDTH, default 8: tid width.
REQ-003 SHALL have parameter TDEST_WIDTH, default 8: tdest width.
REQ-004 SHALL have parameter TUSER_WIDTH, default 8: tuser width.
REQ-005 SHALL have parameter DEPTH, default 16: beat storage; power of 2, at least 2.
REQ-006 SHALL have parameter MODE, default CUT_THROUGH: CUT_THROUGH or STORE_FWD.
REQ-007 SHALL have clock and reset: one clock; reset is asynchronous and active-low. Ports: clk input 1, clock; reset_n input 1, async active-low reset.
REQ-008 SHALL have mstr_tvalid, mstr_tdata (8*TDATA_BYTES), mstr_tstrb, mstr_tkeep, mstr_tlast, mstr_tid, mstr_tdest and mstr_tuser as inputs: the upstream beat.
REQ-009 SHALL have mstr_tready output 1: upstream ready.
REQ-010 SHALL have slv_tvalid, slv_tdata, slv_tstrb, slv_tkeep, slv_tlast, slv_tid, slv_tdest and slv_tuser as outputs: the downstream beat, same widths as mstr_*.
REQ-011 SHALL have slv_tready input 1: downstream ready.
REQ-012 SHALL have level output clog2(DEPTH+1): beats stored.
REQ-013 SHALL have pkt_count output clog2(DEPTH+1): complete packets (tlast beats) stored.

Function
REQ-014 SHALL accept a beat at a rising edge when mstr_tvalid and mstr_tready are both 1; SHALL pop a beat when slv_tvalid and slv_tready are both 1.
REQ-015 SHALL drive mstr_tready = reset_n AND (level < DEPTH); a beat is never accepted when full, even if a pop occurs in the same cycle.
REQ-016 SHALL make a beat accepted at edge N visible on slv_* after edge N (first-word fall-through); empty-to-output latency is 1 cycle.
REQ-017 SHALL hold all slv_* payload stable while slv_tvalid=1 and slv_tready=0 (AXI-Stream rule).
REQ-018 SHALL pass all payload fields bit-exact and in order; there is no reordering, merging or dropping.
REQ-019 SHALL, in CUT_THROUGH mode, drive slv_tvalid = (level > 0).
REQ-020 SHALL, in STORE_FWD mode, drive slv_tvalid = (level > 0) AND ((pkt_count > 0) OR (level == DEPTH)); forced release when full prevents deadlock on packets longer than DEPTH.
REQ-021 SHALL change level by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
REQ-022 SHALL change pkt_count by +1 on a push with tlast=1, -1 on a pop with tlast=1, and 0 when both occur in the same cycle.
REQ-023 SHALL wrap read and write pointers modulo DEPTH; full and empty are distinguished by level, not by pointer equality.
REQ-024 SHALL handle a simultaneous push and pop on empty as a push only (slv_tvalid is 0 that cycle).

Reset
REQ-025 SHALL, while reset_n=0, force level=0, pkt_count=0, pointers=0, slv_tvalid=0 and mstr_tready=0; slv payload is undefined.
REQ-026 SHALL discard all stored beats on reset assertion mid-packet; the first beat after release starts a fresh stream.
REQ-027 SHALL raise mstr_tready in the first cycle reset_n is 1.

Structure
REQ-028 SHALL have package uvmt_axis_st_buf_pkg hold the mode enum (CUT_THROUGH, STORE_FWD) and the default parameter constants.
REQ-029 SHALL place the storage array in sub-module uvmt_axis_st_buf_mem: DEPTH x packed beat width, one write port, one async-read port, no reset on the array.
REQ-030 SHALL keep the pointer, level and pkt_count logic in the top module.

Verification
REQ-031 SHALL cover CUT_THROUGH streaming: push 0x1..0x40 with slv_tready=1 -> outputs 0x1..0x40 in order, 1-cycle latency, level at most 1.
REQ-032 SHALL cover fill-to-full: with DEPTH=16 and slv_tready=0, push 20 beats -> 16 accepted, mstr_tready=0 after the 16th, level=16; release -> all 16 out.
REQ-033 SHALL cover STORE_FWD hold: push 5-beat packet with tlast on beat 5 -> slv_tvalid stays 0 until the cycle after beat 5 is accepted, pkt_count=1.
REQ-034 SHALL cover STORE_FWD oversize: push 20 beats with no tlast, DEPTH=16 -> forced release at level=16 and all 20 delivered.
REQ-035 SHALL cover simultaneous tlast push and pop: pkt_count stays constant and level stays constant.
REQ-036 SHALL cover reset mid-packet: assert reset_n=0 at level=7 -> level=0, slv_tvalid=0 immediately; new packet afterward delivered intact.

Source files
------------

// File: rtl/uvmt_axis_st_buf_pkg.sv
// Shared types and default parameters for the AXI-Stream beat buffer.
package uvmt_axis_st_buf_pkg;

  typedef enum logic {
    CUT_THROUGH = 1'b0,
    STORE_FWD   = 1'b1
  } buf_mode_e;

  localparam int        DEF_TDATA_BYTES = 4;
  localparam int        DEF_TID_WIDTH   = 8;
  localparam int        DEF_TDEST_WIDTH = 8;
  localparam int        DEF_TUSER_WIDTH = 8;
  localparam int        DEF_DEPTH       = 16;
  localparam buf_mode_e DEF_MODE        = CUT_THROUGH;

  // Packed beat: tdata, tstrb, tkeep, tlast, tid, tdest, tuser.
  function automatic int beat_width(input int bytes, input int tid_w,
                                    input int tdest_w, input int tuser_w);
    return 8 * bytes + 2 * bytes + 1 + tid_w + tdest_w + tuser_w;
  endfunction

endpackage

// File: rtl/uvmt_axis_st_buf_mem.sv
// Beat storage: one synchronous write port, one asynchronous read port, no reset.
module uvmt_axis_st_buf_mem
  import uvmt_axis_st_buf_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uvmt_axis_st_buf_dut.sv
// AXI-Stream beat buffer with first-word fall-through output and an optional
// store-and-forward release gate.
module uvmt_axis_st_buf_dut
  import uvmt_axis_st_buf_pkg::*;
#(
  parameter int        TDATA_BYTES = DEF_TDATA_BYTES,
  parameter int        TID_WIDTH   = DEF_TID_WIDTH,
  parameter int        TDEST_WIDTH = DEF_TDEST_WIDTH,
  parameter int        TUSER_WIDTH = DEF_TUSER_WIDTH,
  parameter int        DEPTH       = DEF_DEPTH,
  parameter buf_mode_e MODE        = DEF_MODE
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         mstr_tvalid,
  input  logic [8*TDATA_BYTES-1:0]     mstr_tdata,
  input  logic [TDATA_BYTES-1:0]       mstr_tstrb,
  input  logic [TDATA_BYTES-1:0]       mstr_tkeep,
  input  logic                         mstr_tlast,
  input  logic [TID_WIDTH-1:0]         mstr_tid,
  input  logic [TDEST_WIDTH-1:0]       mstr_tdest,
  input  logic [TUSER_WIDTH-1:0]       mstr_tuser,
  output logic                         mstr_tready,
  output logic                         slv_tvalid,
  output logic [8*TDATA_BYTES-1:0]     slv_tdata,
  output logic [TDATA_BYTES-1:0]       slv_tstrb,
  output logic [TDATA_BYTES-1:0]       slv_tkeep,
  output logic                         slv_tlast,
  output logic [TID_WIDTH-1:0]         slv_tid,
  output logic [TDEST_WIDTH-1:0]       slv_tdest,
  output logic [TUSER_WIDTH-1:0]       slv_tuser,
  input  logic                         slv_tready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [$clog2(DEPTH+1)-1:0]   pkt_count
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int BW = beat_width(TDATA_BYTES, TID_WIDTH, TDEST_WIDTH, TUSER_WIDTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level, r_pkt_count;
  logic          w_push, w_pop, w_release;
  logic [BW-1:0] w_wr_beat, w_rd_beat;

  // Handshake: a beat moves on a rising edge only when valid and ready are
  // both 1 on that side; valid never depends on ready of the same side.
  assign mstr_tready = reset_n & (r_level < FULL_LVL);
  assign w_release   = (MODE == CUT_THROUGH) | (r_pkt_count != '0) | (r_level == FULL_LVL);
  assign slv_tvalid  = (r_level != '0) & w_release;
  assign w_push      = mstr_tvalid & mstr_tready;
  assign w_pop       = slv_tvalid & slv_tready;

  assign w_wr_beat = {mstr_tdata, mstr_tstrb, mstr_tkeep, mstr_tlast,
                      mstr_tid, mstr_tdest, mstr_tuser};
  assign {slv_tdata, slv_tstrb, slv_tkeep, slv_tlast,
          slv_tid, slv_tdest, slv_tuser} = w_rd_beat;

  uvmt_axis_st_buf_mem #(
    .DEPTH (DEPTH),
    .WIDTH (BW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_beat),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_beat)
  );

  // Pointers wrap naturally at DEPTH (power of 2); fullness comes from r_level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      case ({w_push & mstr_tlast, w_pop & slv_tlast})
        2'b10:   r_pkt_count <= r_pkt_count + LW'(1);
        2'b01:   r_pkt_count <= r_pkt_count - LW'(1);
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

  assign level     = r_level;
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_uvmt_axis_st_buf_dut.sv
// Directed bench for the AXI-Stream buffer: one cut-through and one
// store-and-forward instance share inputs; each test observes one of them.
module tb_uvmt_axis_st_buf_dut;
  import uvmt_axis_st_buf_pkg::*;

  localparam int BW = 65;
  localparam int LW = 5;

  logic        clk, reset_n;
  logic        mstr_tvalid, mstr_tlast, slv_tready;
  logic [31:0] mstr_tdata;
  logic [3:0]  mstr_tstrb, mstr_tkeep;
  logic [7:0]  mstr_tid, mstr_tdest, mstr_tuser;

  logic        ct_mstr_tready, ct_slv_tvalid, ct_slv_tlast;
  logic [31:0] ct_slv_tdata;
  logic [3:0]  ct_slv_tstrb, ct_slv_tkeep;
  logic [7:0]  ct_slv_tid, ct_slv_tdest, ct_slv_tuser;
  logic [LW-1:0] ct_level, ct_pkt_count;

  logic        sf_mstr_tready, sf_slv_tvalid, sf_slv_tlast;
  logic [31:0] sf_slv_tdata;
  logic [3:0]  sf_slv_tstrb, sf_slv_tkeep;
  logic [7:0]  sf_slv_tid, sf_slv_tdest, sf_slv_tuser;
  logic [LW-1:0] sf_level, sf_pkt_count;

  uvmt_axis_st_buf_dut #(.TDATA_BYTES(4), .TID_WIDTH(8), .TDEST_WIDTH(8),
    .TUSER_WIDTH(8), .DEPTH(16), .MODE(CUT_THROUGH)) u_ct (
    .clk(clk), .reset_n(reset_n),
    .mstr_tvalid(mstr_tvalid), .mstr_tdata(mstr_tdata), .mstr_tstrb(mstr_tstrb),
    .mstr_tkeep(mstr_tkeep), .mstr_tlast(mstr_tlast), .mstr_tid(mstr_tid),
    .mstr_tdest(mstr_tdest), .mstr_tuser(mstr_tuser), .mstr_tready(ct_mstr_tready),
    .slv_tvalid(ct_slv_tvalid), .slv_tdata(ct_slv_tdata), .slv_tstrb(ct_slv_tstrb),
    .slv_tkeep(ct_slv_tkeep), .slv_tlast(ct_slv_tlast), .slv_tid(ct_slv_tid),
    .slv_tdest(ct_slv_tdest), .slv_tuser(ct_slv_tuser), .slv_tready(slv_tready),
    .level(ct_level), .pkt_count(ct_pkt_count));

  uvmt_axis_st_buf_dut #(.TDATA_BYTES(4), .TID_WIDTH(8), .TDEST_WIDTH(8),
    .TUSER_WIDTH(8), .DEPTH(16), .MODE(STORE_FWD)) u_sf (
    .clk(clk), .reset_n(reset_n),
    .mstr_tvalid(mstr_tvalid), .mstr_tdata(mstr_tdata), .mstr_tstrb(mstr_tstrb),
    .mstr_tkeep(mstr_tkeep), .mstr_tlast(mstr_tlast), .mstr_tid(mstr_tid),
    .mstr_tdest(mstr_tdest), .mstr_tuser(mstr_tuser), .mstr_tready(sf_mstr_tready),
    .slv_tvalid(sf_slv_tvalid), .slv_tdata(sf_slv_tdata), .slv_tstrb(sf_slv_tstrb),
    .slv_tkeep(sf_slv_tkeep), .slv_tlast(sf_slv_tlast), .slv_tid(sf_slv_tid),
    .slv_tdest(sf_slv_tdest), .slv_tuser(sf_slv_tuser), .slv_tready(slv_tready),
    .level(sf_level), .pkt_count(sf_pkt_count));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selected-instance view: sel=0 cut-through, sel=1 store-and-forward.
  logic          sel;
  logic          o_tready, o_tvalid;
  logic [BW-1:0] o_beat;
  logic [LW-1:0] o_level, o_pkt;

  always_comb begin
    o_tready = sel ? sf_mstr_tready : ct_mstr_tready;
    o_tvalid = sel ? sf_slv_tvalid  : ct_slv_tvalid;
    o_level  = sel ? sf_level       : ct_level;
    o_pkt    = sel ? sf_pkt_count   : ct_pkt_count;
    o_beat   = sel ? {sf_slv_tdata, sf_slv_tstrb, sf_slv_tkeep, sf_slv_tlast,
                      sf_slv_tid, sf_slv_tdest, sf_slv_tuser}
                   : {ct_slv_tdata, ct_slv_tstrb, ct_slv_tkeep, ct_slv_tlast,
                      ct_slv_tid, ct_slv_tdest, ct_slv_tuser};
  end

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] e, b;
  logic          p, q;
  logic [LW-1:0] lv;
  int            n_tests, n_fail;

  function automatic logic [BW-1:0] make_beat(input logic [31:0] v, input logic last);
    return {v, ~v[3:0], v[3:0], last, v[7:0] ^ 8'h5A, v[7:0] + 8'd1, ~v[7:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_beat(input logic [31:0] v, input logic last);
    mstr_tvalid = 1'b1;
    mstr_tdata  = v;
    mstr_tstrb  = ~v[3:0];
    mstr_tkeep  = v[3:0];
    mstr_tlast  = last;
    mstr_tid    = v[7:0] ^ 8'h5A;
    mstr_tdest  = v[7:0] + 8'd1;
    mstr_tuser  = ~v[7:0];
  endtask

  // Samples handshakes at the falling edge, then returns 1 ns after the rise.
  task automatic run_cycle(output logic pushed, output logic popped,
                           output logic [BW-1:0] beat, output logic [LW-1:0] lvl);
    @(negedge clk);
    pushed = mstr_tvalid && o_tready;
    popped = o_tvalid && slv_tready;
    beat   = o_beat;
    lvl    = o_level;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    mstr_tvalid = 1'b0;
    mstr_tlast  = 1'b0;
    slv_tready  = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; mstr_tvalid = 1'b0; slv_tready = 1'b0;
    @(negedge clk);
    n_tests++; if ({ct_mstr_tready, sf_mstr_tready} !== 2'b00) begin n_fail++;
      $display("FAIL reset_tready: got %b expected 00", {ct_mstr_tready, sf_mstr_tready}); end
    n_tests++; if ({ct_slv_tvalid, sf_slv_tvalid} !== 2'b00) begin n_fail++;
      $display("FAIL reset_tvalid: got %b expected 00", {ct_slv_tvalid, sf_slv_tvalid}); end
    n_tests++; if ({ct_level, sf_level, ct_pkt_count, sf_pkt_count} !== 20'd0) begin n_fail++;
      $display("FAIL reset_counts: got %0h expected 0", {ct_level, sf_level, ct_pkt_count, sf_pkt_count}); end
    @(posedge clk); #1 reset_n = 1'b1;
    #1;
    n_tests++; if ({ct_mstr_tready, sf_mstr_tready} !== 2'b11) begin n_fail++;
      $display("FAIL release_tready: got %b expected 11", {ct_mstr_tready, sf_mstr_tready}); end
  endtask

  task automatic test_stream();
    int v, outs;
    sel = 1'b0; do_reset(); slv_tready = 1'b1; v = 1; outs = 0;
    for (int c = 0; c < 200 && outs < 64; c++) begin
      if (v <= 64) set_beat(v, v == 64); else mstr_tvalid = 1'b0;
      run_cycle(p, q, b, lv);
      if (c == 0) begin
        n_tests++; if (q !== 1'b0) begin n_fail++;
          $display("FAIL stream_empty_pop: got %b expected 0", q); end
      end
      if (q) begin
        n_tests++; if (exp_q.size() != 1) begin n_fail++;
          $display("FAIL stream_latency: got depth %0d expected 1", exp_q.size()); end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_tests++; if (b !== e) begin n_fail++;
            $display("FAIL stream_data: got %h expected %h", b, e); end
        end
        outs++;
      end
      if (p) begin exp_q.push_back(make_beat(v, v == 64)); v++; end
      n_tests++; if (o_level > 5'd1) begin n_fail++;
        $display("FAIL stream_level: got %0d expected <=1", o_level); end
    end
    mstr_tvalid = 1'b0;
    n_tests++; if (outs != 64) begin n_fail++;
      $display("FAIL stream_count: got %0d expected 64", outs); end
  endtask

  task automatic test_fill();
    int v, acc;
    sel = 1'b0; do_reset(); slv_tready = 1'b0; v = 1; acc = 0;
    for (int c = 0; c < 20; c++) begin
      set_beat(v, 1'b0);
      run_cycle(p, q, b, lv);
      if (p) begin
        exp_q.push_back(make_beat(v, 1'b0)); v++; acc++;
        if (acc == 16) begin
          n_tests++; if (o_tready !== 1'b0) begin n_fail++;
            $display("FAIL fill_tready_at_16: got %b expected 0", o_tready); end
        end
      end
    end
    n_tests++; if (acc != 16) begin n_fail++;
      $display("FAIL fill_accepted: got %0d expected 16", acc); end
    n_tests++; if (o_level !== 5'd16) begin n_fail++;
      $display("FAIL fill_level: got %0d expected 16", o_level); end
    slv_tready = 1'b1;
    set_beat(v, 1'b0);
    run_cycle(p, q, b, lv);
    n_tests++; if ({p, q} !== 2'b01) begin n_fail++;
      $display("FAIL full_push_pop: got push/pop %b expected 01", {p, q}); end
    if (q && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++; if (b !== e) begin n_fail++;
        $display("FAIL fill_data: got %h expected %h", b, e); end
    end
    n_tests++; if (o_level !== 5'd15) begin n_fail++;
      $display("FAIL full_pop_level: got %0d expected 15", o_level); end
    mstr_tvalid = 1'b0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      run_cycle(p, q, b, lv);
      if (q) begin
        e = exp_q.pop_front();
        n_tests++; if (b !== e) begin n_fail++;
          $display("FAIL fill_data: got %h expected %h", b, e); end
      end
    end
    n_tests++; if (exp_q.size() != 0 || o_level !== 5'd0) begin n_fail++;
      $display("FAIL fill_drain: got %0d left level %0d expected 0 0", exp_q.size(), o_level); end
  endtask

  task automatic test_sf_hold();
    sel = 1'b1; do_reset(); slv_tready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      set_beat(32'h100 + i, i == 5);
      run_cycle(p, q, b, lv);
      n_tests++; if ({p, q} !== 2'b10) begin n_fail++;
        $display("FAIL sf_hold_beat%0d: got push/pop %b expected 10", i, {p, q}); end
      if (p) exp_q.push_back(make_beat(32'h100 + i, i == 5));
    end
    mstr_tvalid = 1'b0;
    n_tests++; if ({o_tvalid, o_pkt, o_level} !== {1'b1, 5'd1, 5'd5}) begin n_fail++;
      $display("FAIL sf_release: got valid/pkt/level %b/%0d/%0d expected 1/1/5", o_tvalid, o_pkt, o_level); end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      run_cycle(p, q, b, lv);
      if (q) begin
        e = exp_q.pop_front();
        n_tests++; if (b !== e) begin n_fail++;
          $display("FAIL sf_hold_data: got %h expected %h", b, e); end
      end
    end
    n_tests++; if (exp_q.size() != 0 || o_pkt !== 5'd0) begin n_fail++;
      $display("FAIL sf_hold_drain: got %0d left pkt %0d expected 0 0", exp_q.size(), o_pkt); end
  endtask

  task automatic test_sf_oversize();
    int  v, outs;
    logic first, term;
    sel = 1'b1; do_reset(); slv_tready = 1'b1; v = 1; outs = 0; first = 1'b0; term = 1'b0;
    for (int c = 0; c < 100 && v <= 20; c++) begin
      set_beat(v, 1'b0);
      run_cycle(p, q, b, lv);
      if (q) begin
        if (!first) begin
          first = 1'b1;
          n_tests++; if (lv !== 5'd16 || v != 17) begin n_fail++;
            $display("FAIL sf_forced_release: got level %0d after %0d beats expected 16 16", lv, v - 1); end
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_tests++; if (b !== e) begin n_fail++;
            $display("FAIL sf_oversize_data: got %h expected %h", b, e); end
        end
        outs++;
      end
      if (p) begin exp_q.push_back(make_beat(v, 1'b0)); v++; end
    end
    n_tests++; if (v != 21 || !first) begin n_fail++;
      $display("FAIL sf_oversize_accept: got %0d beats released %b expected 20 1", v - 1, first); end
    for (int c = 0; c < 100 && (!term || exp_q.size() > 0); c++) begin
      if (!term) set_beat(21, 1'b1); else mstr_tvalid = 1'b0;
      run_cycle(p, q, b, lv);
      if (q && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++; if (b !== e) begin n_fail++;
          $display("FAIL sf_oversize_data: got %h expected %h", b, e); end
        outs++;
      end
      if (p) begin exp_q.push_back(make_beat(21, 1'b1)); term = 1'b1; end
    end
    mstr_tvalid = 1'b0;
    n_tests++; if (outs != 21 || o_level !== 5'd0) begin n_fail++;
      $display("FAIL sf_oversize_count: got %0d out level %0d expected 21 0", outs, o_level); end
  endtask

  task automatic test_simul_last();
    sel = 1'b1; do_reset(); slv_tready = 1'b0;
    set_beat(32'hA1, 1'b1);
    run_cycle(p, q, b, lv);
    if (p) exp_q.push_back(make_beat(32'hA1, 1'b1));
    n_tests++; if ({p, o_level, o_pkt} !== {1'b1, 5'd1, 5'd1}) begin n_fail++;
      $display("FAIL simul_setup: got push/level/pkt %b/%0d/%0d expected 1/1/1", p, o_level, o_pkt); end
    slv_tready = 1'b1;
    set_beat(32'hB2, 1'b1);
    run_cycle(p, q, b, lv);
    n_tests++; if ({p, q} !== 2'b11) begin n_fail++;
      $display("FAIL simul_handshake: got push/pop %b expected 11", {p, q}); end
    if (q && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++; if (b !== e) begin n_fail++;
        $display("FAIL simul_data: got %h expected %h", b, e); end
    end
    if (p) exp_q.push_back(make_beat(32'hB2, 1'b1));
    n_tests++; if ({o_level, o_pkt} !== {5'd1, 5'd1}) begin n_fail++;
      $display("FAIL simul_counts: got level/pkt %0d/%0d expected 1/1", o_level, o_pkt); end
    mstr_tvalid = 1'b0;
    run_cycle(p, q, b, lv);
    if (q && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++; if (b !== e) begin n_fail++;
        $display("FAIL simul_data: got %h expected %h", b, e); end
    end
    n_tests++; if ({q, o_level, o_pkt} !== {1'b1, 5'd0, 5'd0}) begin n_fail++;
      $display("FAIL simul_drain: got pop/level/pkt %b/%0d/%0d expected 1/0/0", q, o_level, o_pkt); end
  endtask

  task automatic test_reset_mid();
    int v, outs;
    sel = 1'b0; do_reset(); slv_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_beat(32'h200 + i, 1'b0);
      run_cycle(p, q, b, lv);
    end
    mstr_tvalid = 1'b0;
    n_tests++; if (o_level !== 5'd7) begin n_fail++;
      $display("FAIL mid_level: got %0d expected 7", o_level); end
    reset_n = 1'b0;
    #1;
    n_tests++; if ({o_level, o_pkt, o_tvalid, o_tready} !== 12'd0) begin n_fail++;
      $display("FAIL mid_reset_async: got level/pkt/valid/ready %0d/%0d/%b/%b expected 0/0/0/0",
               o_level, o_pkt, o_tvalid, o_tready); end
    exp_q.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    slv_tready = 1'b1; v = 1; outs = 0;
    for (int c = 0; c < 20 && outs < 3; c++) begin
      if (v <= 3) set_beat(32'h300 + v, v == 3); else mstr_tvalid = 1'b0;
      run_cycle(p, q, b, lv);
      if (q) begin
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = '0;
        n_tests++; if (b !== e) begin n_fail++;
          $display("FAIL mid_new_data: got %h expected %h", b, e); end
        outs++;
      end
      if (p) begin exp_q.push_back(make_beat(32'h300 + v, v == 3)); v++; end
    end
    mstr_tvalid = 1'b0;
    n_tests++; if (outs != 3 || o_level !== 5'd0) begin n_fail++;
      $display("FAIL mid_new_count: got %0d out level %0d expected 3 0", outs, o_level); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_tests = 0; n_fail = 0; sel = 1'b0;
    reset_n = 1'b0; mstr_tvalid = 1'b0; mstr_tlast = 1'b0; slv_tready = 1'b0;
    mstr_tdata = '0; mstr_tstrb = '0; mstr_tkeep = '0;
    mstr_tid = '0; mstr_tdest = '0; mstr_tuser = '0;
    test_reset();
    test_stream();
    test_fill();
    test_sf_hold();
    test_sf_oversize();
    test_simul_last();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
